// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types, defaults and ratio helper for the divider controller
package div_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam int CNT_W_DEF   = 4;
    localparam int DEF_DIV_DEF = 1;

    // High-phase length H = (N+1)>>1 with N = code+1; odd N gets the extra cycle high
    function automatic int unsigned half_ratio(input int unsigned code);
        return (code + 2) >> 1;
    endfunction

endpackage

// File: rtl/div_cfg_shadow.sv
// div_cfg_shadow: one-deep ratio shadow register with valid/ready, illegal-code flag and copy strobe
module div_cfg_shadow
    import div_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             boundary,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             copy,
    output logic [CNT_W-1:0] shadow_div
);

    logic             full_q, full_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] sh_q, sh_d;
    logic             accept;

    // Accept when empty; code 0 is swallowed and flagged, a legal code fills the shadow until the core copies it
    always_comb begin
        accept = cfg_valid && !full_q;
        copy   = full_q && boundary;
        full_d = copy ? 1'b0 : (accept && cfg_div != '0) ? 1'b1 : full_q;
        sh_d   = (accept && cfg_div != '0) ? cfg_div : sh_q;
        err_d  = accept && cfg_div == '0;
    end

    // Shadow state registers; reset drops any pending ratio
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            err_q  <= 1'b0;
            sh_q   <= '0;
        end else begin
            full_q <= full_d;
            err_q  <= err_d;
            sh_q   <= sh_d;
        end
    end

    assign cfg_ready  = !full_q;
    assign cfg_err    = err_q;
    assign shadow_div = sh_q;

endmodule

// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: run/stop FSM, period counter and glitch-free ratio update for the frequency divider
module div_ratio_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] syscnt,
    output logic             tick,
    output logic             div_out,
    output logic             running
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic             tick_q, tick_d;
    logic             div_q, div_d;
    logic             run_q, run_d;
    logic [CNT_W:0]   h;
    logic             wrap, boundary, copy;
    logic [CNT_W-1:0] sh_div;

    // The active code is N-1, so the period ends when the count equals it
    assign wrap     = (state_q != IDLE) && (cnt_q == act_q);
    assign boundary = (state_q == IDLE) || wrap;

    div_cfg_shadow #(.CNT_W(CNT_W)) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .boundary   (boundary),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .copy       (copy),
        .shadow_div (sh_div)
    );

    // Next state, count and ratio; outputs are derived from the next values so they register cleanly
    always_comb begin
        unique case (state_q)
            IDLE:     state_d = (start && !stop) ? RUN : IDLE;
            RUN:      state_d = stop ? STOPPING : RUN;
            STOPPING: state_d = (start && !stop) ? RUN : (wrap ? IDLE : STOPPING);
            default:  state_d = IDLE;
        endcase
        cnt_d  = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
        act_d  = copy ? sh_div : act_q;
        h      = (CNT_W+1)'(half_ratio(32'(act_d)));
        run_d  = state_d != IDLE;
        tick_d = run_d && (cnt_d == act_d);
        div_d  = run_d && ({1'b0, cnt_d} < h);
    end

    // Core registers, all outputs included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= CNT_W'(DEF_DIV);
            tick_q  <= 1'b0;
            div_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            run_q   <= run_d;
        end
    end

    assign syscnt  = cnt_q;
    assign tick    = tick_q;
    assign div_out = div_q;
    assign running = run_q;

endmodule
